// File: rtl/inst_fetch.sv
// Instruction fetch stage: owns the PC, drives a 1-cycle-latency instruction rom and
// hands {inst, pc} pairs to decode over valid/ready, with a one-entry skid buffer and redirect flush.
module inst_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RST,
  output logic [31:0] IMEM_A,
  input  logic [31:0] IMEM_Q,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_inst,
  output logic [31:0] out_pc
);

  logic [31:0] pc_q, pc_d;
  logic        req_valid_q, req_valid_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        skid_valid_q, skid_valid_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc_q, skid_pc_d;
  logic        issue;

  assign IMEM_A = pc_q;

  // A new fetch may only go out when the word in front of decode is leaving,
  // or nothing is in flight; this keeps skid and rom response mutually exclusive.
  assign issue = ~redirect_valid & (out_ready | (~skid_valid_q & ~req_valid_q));

  always_comb begin
    out_valid = (skid_valid_q | req_valid_q) & ~redirect_valid;
    out_inst  = skid_inst_q;
    out_pc    = skid_pc_q;
    if (!skid_valid_q && req_valid_q) begin
      out_inst = IMEM_Q;
      out_pc   = req_pc_q;
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets a default before any branch, so no path
    // leaves one unassigned and no latch is inferred.
    pc_d         = pc_q;
    req_valid_d  = 1'b0;
    req_pc_d     = req_pc_q;
    skid_valid_d = skid_valid_q;
    skid_inst_d  = skid_inst_q;
    skid_pc_d    = skid_pc_q;

    if (redirect_valid) begin
      pc_d         = redirect_pc & ~32'd3;
      skid_valid_d = 1'b0;
    end else begin
      if (issue) begin
        req_valid_d = 1'b1;
        req_pc_d    = pc_q;
        pc_d        = pc_q + 32'd4;
      end
      if (req_valid_q && !skid_valid_q && !out_ready) begin
        skid_valid_d = 1'b1;
        skid_inst_d  = IMEM_Q;
        skid_pc_d    = req_pc_q;
      end else if (skid_valid_q && out_ready) begin
        skid_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge CLK) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (RST) begin
      pc_q         <= RESET_PC;
      req_valid_q  <= 1'b0;
      req_pc_q     <= 32'd0;
      skid_valid_q <= 1'b0;
      skid_inst_q  <= 32'd0;
      skid_pc_q    <= 32'd0;
    end else begin
      pc_q         <= pc_d;
      req_valid_q  <= req_valid_d;
      req_pc_q     <= req_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_inst_q  <= skid_inst_d;
      skid_pc_q    <= skid_pc_d;
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: rom model, stream-level reference model checked every cycle,
// and directed scenarios with hand-computed literal expectations.
module tb_inst_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        CLK = 1'b0;
  logic        RST;
  logic [31:0] IMEM_A;
  logic [31:0] IMEM_Q = 32'd0;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;

  int passed = 0;
  int total  = 0;

  inst_fetch #(.RESET_PC(RESET_PC)) dut (
    .CLK            (CLK),
    .RST            (RST),
    .IMEM_A         (IMEM_A),
    .IMEM_Q         (IMEM_Q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_inst       (out_inst),
    .out_pc         (out_pc)
  );

  always #5 CLK = ~CLK;

  // rom contents: word i holds 0x100 + i, for any byte address
  function automatic logic [31:0] rom_word(input logic [31:0] a);
    return 32'h100 + (a >> 2);
  endfunction

  always @(posedge CLK) IMEM_Q <= rom_word(IMEM_A);

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
  endtask

  // Stream model: exp_pc is the next word decode must see; since_restart counts
  // edges since the last reset/redirect. Outputs are valid from the 2nd cycle on.
  logic        model_on = 1'b0;
  logic [31:0] exp_pc   = 32'd0;
  int          since_restart = 0;

  always @(negedge CLK) begin
    logic exp_valid;
    exp_valid = model_on && !redirect_valid && (since_restart >= 1);
    if (model_on) begin
      check("m_out_valid", {31'd0, out_valid}, {31'd0, exp_valid});
      if (since_restart == 0) check("m_fetch_target", IMEM_A, exp_pc);
      if (exp_valid) begin
        check("m_out_pc", out_pc, exp_pc);
        check("m_out_inst", out_inst, rom_word(exp_pc));
        check("m_pc_ahead", IMEM_A, exp_pc + 32'd4);
      end
    end
    if (RST) begin
      model_on      = 1'b1;
      exp_pc        = RESET_PC;
      since_restart = 0;
    end else if (model_on && redirect_valid) begin
      exp_pc        = redirect_pc & ~32'd3;
      since_restart = 0;
    end else if (model_on) begin
      if (exp_valid && out_ready) exp_pc = exp_pc + 32'd4;
      if (since_restart < 1000) since_restart++;
    end
  end

  task automatic cycle();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    logic [31:0] pat;
    RST = 1'b1; redirect_valid = 1'b0; redirect_pc = 32'd0; out_ready = 1'b1;
    repeat (2) cycle();

    // 1: stream from reset
    RST = 1'b0;
    @(negedge CLK); check("t1_idle_valid", {31'd0, out_valid}, 32'd0);
    check("t1_imem_a", IMEM_A, 32'h0);
    cycle(); @(negedge CLK);
    check("t1_pc0", out_pc, 32'h0); check("t1_inst0", out_inst, 32'h100);
    cycle(); @(negedge CLK);
    check("t1_pc1", out_pc, 32'h4); check("t1_inst1", out_inst, 32'h101);

    // 2: stall for 3 cycles
    cycle();
    cycle(); out_ready = 1'b0;
    @(negedge CLK); check("t2_stall_pc", out_pc, 32'hC);
    cycle(); cycle();
    @(negedge CLK);
    check("t2_frozen_pc", out_pc, 32'hC); check("t2_frozen_inst", out_inst, 32'h103);
    check("t2_pc_one_ahead", IMEM_A, 32'h10);
    cycle(); out_ready = 1'b1;
    @(negedge CLK); check("t2_release_pc", out_pc, 32'hC);
    cycle(); @(negedge CLK);
    check("t2_resume_pc", out_pc, 32'h10); check("t2_resume_inst", out_inst, 32'h104);

    // 3: redirect during an active transfer
    cycle(); redirect_valid = 1'b1; redirect_pc = 32'h43;
    @(negedge CLK); check("t3_redir_valid", {31'd0, out_valid}, 32'd0);
    cycle(); redirect_valid = 1'b0;
    @(negedge CLK); check("t3_idle_valid", {31'd0, out_valid}, 32'd0);
    cycle(); @(negedge CLK);
    check("t3_pc", out_pc, 32'h40); check("t3_inst", out_inst, 32'h110);

    // 4: redirect while skid holds a word and decode is stalled
    cycle(); out_ready = 1'b0;
    cycle(); redirect_valid = 1'b1; redirect_pc = 32'h200;
    @(negedge CLK); check("t4_redir_valid", {31'd0, out_valid}, 32'd0);
    cycle(); redirect_valid = 1'b0; out_ready = 1'b1;
    @(negedge CLK); check("t4_idle_valid", {31'd0, out_valid}, 32'd0);
    cycle(); @(negedge CLK);
    check("t4_pc", out_pc, 32'h200); check("t4_inst", out_inst, 32'h180);

    // back-to-back redirects: last one wins
    cycle(); redirect_valid = 1'b1; redirect_pc = 32'h300;
    cycle(); redirect_pc = 32'h502;
    cycle(); redirect_valid = 1'b0;
    cycle(); @(negedge CLK);
    check("tb2b_pc", out_pc, 32'h500); check("tb2b_inst", out_inst, 32'h240);

    // 5: wrap at the top of the address space
    cycle(); redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    cycle(); redirect_valid = 1'b0;
    cycle(); @(negedge CLK);
    check("t5_pc_top", out_pc, 32'hFFFF_FFFC); check("t5_inst_top", out_inst, 32'h4000_00FF);
    cycle(); @(negedge CLK);
    check("t5_pc_wrap", out_pc, 32'h0); check("t5_inst_wrap", out_inst, 32'h100);

    // irregular stall pattern, covered by the stream model
    pat = 32'b1011_0011_1000_1101_0110_0111_0001_1110;
    for (int i = 0; i < 32; i++) begin
      cycle(); out_ready = pat[i];
    end

    // 6: reset mid-stream (also asserting redirect to show reset wins)
    cycle(); RST = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h700;
    cycle(); RST = 1'b0; redirect_valid = 1'b0; out_ready = 1'b1;
    @(negedge CLK); check("t6_valid_after_rst", {31'd0, out_valid}, 32'd0);
    check("t6_imem_a", IMEM_A, RESET_PC);
    cycle(); @(negedge CLK);
    check("t6_pc", out_pc, RESET_PC); check("t6_inst", out_inst, 32'h100);
    for (int i = 0; i < 8; i++) begin
      cycle(); out_ready = (i % 3) != 0;
    end
    cycle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
